// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption core, one round per clock.
// The cipher key is expanded forward into an 11-entry round-key store, then
// the rounds run backwards using rk10..rk0.
//
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   in_valid      cipher_text / cipher_key valid this cycle
//   in_ready      high only in IDLE
//   cipher_text   128-bit ciphertext, bits [127:120] = byte 0
//   cipher_key    128-bit AES key, same byte order
//   plain_text    registered plaintext, held until the next result
//   plain_ready   one-cycle pulse when plain_text is new
//   dbg_state     current FSM state (0 IDLE,1 KEXP,2 INIT,3 ROUND,4 FINAL)
//
// Handshake: a block transfers at a rising edge where in_valid & in_ready are
// both high. Inputs are sampled only on that edge. in_valid while busy is ignored.
//
// KEY_CACHE=1: a cipher_key equal to the last fully expanded key skips
// expansion. rk0 doubles as the cached key because the store is only
// rewritten on a miss, and a miss clears the valid bit first.
module aes_inv_cipher #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic [127:0] plain_text,
  output logic         plain_ready,
  output logic [2:0]   dbg_state
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEXP  = 3'd1,
    ST_INIT  = 3'd2,
    ST_ROUND = 3'd3,
    ST_FINAL = 3'd4
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] f_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant in GF(2^8), poly 0x11b.
  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] a2, a4, a8;
    a2 = f_xt(a);
    a4 = f_xt(a2);
    a8 = f_xt(a4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
           (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
  endfunction

  // Row r of column c is byte 4c+r; InvShiftRows rotates row r right by r.
  function automatic logic [127:0] f_inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = ISBOX[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] f_inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = f_gmul(a0, 4'he) ^ f_gmul(a1, 4'hb) ^ f_gmul(a2, 4'hd) ^ f_gmul(a3, 4'h9);
      o[119-32*c -: 8] = f_gmul(a0, 4'h9) ^ f_gmul(a1, 4'he) ^ f_gmul(a2, 4'hb) ^ f_gmul(a3, 4'hd);
      o[111-32*c -: 8] = f_gmul(a0, 4'hd) ^ f_gmul(a1, 4'h9) ^ f_gmul(a2, 4'he) ^ f_gmul(a3, 4'hb);
      o[103-32*c -: 8] = f_gmul(a0, 4'hb) ^ f_gmul(a1, 4'hd) ^ f_gmul(a2, 4'h9) ^ f_gmul(a3, 4'he);
    end
    return o;
  endfunction

  function automatic logic [7:0] f_rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the forward key schedule: RotWord, SubWord, Rcon on the last word.
  function automatic logic [127:0] f_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]] ^ rc, SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;        // KEXP: next rk index 1..10; ROUND: round 9..1
  logic [127:0]  r_blk;
  logic [127:0]  r_rk [0:10];
  logic          r_cache_vld;
  logic [127:0]  r_plain_text;
  logic          r_plain_ready;

  logic          w_hit;
  logic [127:0]  w_sr_sb;
  logic [127:0]  w_rk_next;

  assign w_hit     = (KEY_CACHE != 0) && r_cache_vld && (cipher_key == r_rk[0]);
  assign w_sr_sb   = f_inv_shift_sub(r_blk);
  assign w_rk_next = f_expand(r_rk[r_cnt - 4'd1], f_rcon(r_cnt));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = w_hit ? ST_INIT : ST_KEXP;
      ST_KEXP:  if (r_cnt == 4'd10) w_state_nxt = ST_INIT;
      ST_INIT:  w_state_nxt = ST_ROUND;
      ST_ROUND: if (r_cnt == 4'd1) w_state_nxt = ST_FINAL;
      ST_FINAL: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE);
    dbg_state   = r_state;
    plain_text  = r_plain_text;
    plain_ready = r_plain_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 4'd0;
      r_blk         <= '0;
      r_cache_vld   <= 1'b0;
      r_plain_text  <= '0;
      r_plain_ready <= 1'b0;
    end else begin
      r_plain_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_blk <= cipher_text;
            if (!w_hit) begin
              r_rk[0]     <= cipher_key;
              r_cache_vld <= 1'b0;
              r_cnt       <= 4'd1;
            end
          end
        end
        ST_KEXP: begin
          r_rk[r_cnt] <= w_rk_next;
          r_cnt       <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) r_cache_vld <= 1'b1;
        end
        ST_INIT: begin
          r_blk <= r_blk ^ r_rk[10];
          r_cnt <= 4'd9;
        end
        ST_ROUND: begin
          r_blk <= f_inv_mix(w_sr_sb ^ r_rk[r_cnt]);
          r_cnt <= r_cnt - 4'd1;
        end
        ST_FINAL: begin
          r_plain_text  <= w_sr_sb ^ r_rk[0];
          r_plain_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb_aes_inv_cipher: bench for aes_inv_cipher (cached build plus a KEY_CACHE=0 build).
module tb_aes_inv_cipher;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid, in_ready, plain_ready;
  logic [127:0] cipher_text, cipher_key, plain_text;
  logic [2:0]   dbg_state;

  logic         nc_in_valid, nc_in_ready, nc_plain_ready;
  logic [127:0] nc_cipher_text, nc_cipher_key, nc_plain_text;
  logic [2:0]   nc_dbg_state;

  aes_inv_cipher #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_text(cipher_text), .cipher_key(cipher_key),
    .plain_text(plain_text), .plain_ready(plain_ready), .dbg_state(dbg_state));

  aes_inv_cipher #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(nc_in_valid), .in_ready(nc_in_ready),
    .cipher_text(nc_cipher_text), .cipher_key(nc_cipher_key),
    .plain_text(nc_plain_text), .plain_ready(nc_plain_ready), .dbg_state(nc_dbg_state));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference encryption model ----------------
  logic [7:0] tb_sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, b, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      tb_sbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   k [16];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) begin
      k[j] = key[127-8*j -: 8];
      s[j] = pt[127-8*j -: 8] ^ k[j];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      w[0] = tb_sbox[k[13]] ^ rc;
      w[1] = tb_sbox[k[14]];
      w[2] = tb_sbox[k[15]];
      w[3] = tb_sbox[k[12]];
      for (int j = 0; j < 4; j++)  k[j] = k[j] ^ w[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      rc = gmul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = tb_sbox[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ k[j];
    end
    o = '0;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];
  logic [127:0] drv_pt;
  int           drv_lat;
  int           n_pulses = 0;
  logic [127:0] mon_e;
  int           mon_l, mon_a;

  // Pop before push so a result and the next acceptance can share a cycle.
  always @(negedge clk) begin
    if (!rst && plain_ready) begin
      n_pulses++;
      check("pulse_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        mon_a = acc_q.pop_front();
        check("plain_text", plain_text, mon_e);
        check("latency", 128'(cyc - mon_a), 128'(mon_l));
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(drv_pt);
      lat_q.push_back(drv_lat);
      acc_q.push_back(cyc + 1);
    end
  end

  task automatic flush_sb();
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] key, input logic [127:0] ct,
                      input logic [127:0] pt, input int lat, input bit hold);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    cipher_key  = key;
    cipher_text = ct;
    drv_pt      = pt;
    drv_lat     = lat;
    in_valid    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept", 128'(got), 128'(1));
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("result_timeout", 128'(exp_q.size()), 128'(0));
    if (exp_q.size() != 0) flush_sb();
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;
  vec_t tbl [5];

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] rkey, rpt;
    int i, p0, t0;
    rst = 1'b1;
    in_valid = 1'b0; cipher_text = '0; cipher_key = '0;
    nc_in_valid = 1'b0; nc_cipher_text = '0; nc_cipher_key = '0;
    drv_pt = '0; drv_lat = 0;
    build_sbox();

    tbl[0] = '{K2, C2, P2, 21};
    tbl[1] = '{K2, C2, P2, 11};
    tbl[2] = '{K1, C1, P1, 21};
    tbl[3] = '{K2, C2, P2, 21};
    tbl[4] = '{K2, C2, P2, 11};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_plain_text", plain_text, 128'(0));
    check("rst_plain_ready", 128'(plain_ready), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));

    // FIPS-197 C.1, pulse width
    send(K1, C1, P1, 21, 1'b0);
    i = 0;
    while (!plain_ready && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("t1_pulse_seen", 128'(plain_ready), 128'(1));
    @(negedge clk);
    check("t1_pulse_width", 128'(plain_ready), 128'(0));
    check("t1_hold_pt", plain_text, P1);
    wait_done(5);

    // table: miss / hit sequencing
    for (int v = 0; v < 5; v++) begin
      send(tbl[v].key, tbl[v].ct, tbl[v].pt, tbl[v].lat, 1'b0);
      wait_done(60);
    end

    // back-to-back with in_valid held high; every key change misses
    send(K1, C1, P1, 21, 1'b1);
    @(negedge clk); check("b2b_busy0", 128'(in_ready), 128'(0));
    send(K2, C2, P2, 21, 1'b1);
    @(negedge clk); check("b2b_busy1", 128'(in_ready), 128'(0));
    send(K1, C1, P1, 21, 1'b0);
    @(negedge clk); check("b2b_busy2", 128'(in_ready), 128'(0));
    wait_done(60);

    // reset in the middle of key expansion
    send(K2, C2, P2, 21, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    flush_sb();
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_plain_text", plain_text, 128'(0));
    check("midrst_plain_ready", 128'(plain_ready), 128'(0));
    p0 = n_pulses;
    repeat (30) @(negedge clk);
    check("midrst_no_pulse", 128'(n_pulses - p0), 128'(0));
    send(K1, C1, P1, 21, 1'b0);
    wait_done(60);

    // input activity while busy has no effect
    send(K1, C1, P1, 11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    cipher_key  = {$urandom, $urandom, $urandom, $urandom};
    cipher_text = {$urandom, $urandom, $urandom, $urandom};
    drv_pt      = {$urandom, $urandom, $urandom, $urandom};
    in_valid    = 1'b1;
    @(negedge clk);
    check("busy_in_ready", 128'(in_ready), 128'(0));
    check("busy_state_round", 128'(dbg_state), 128'(3));
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(60);

    // KEY_CACHE=0 build: same key twice, both full latency
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      nc_cipher_key = K2; nc_cipher_text = C2; nc_in_valid = 1'b1;
      @(negedge clk);
      check("nc_in_ready", 128'(nc_in_ready), 128'(1));
      @(posedge clk); #1;
      t0 = cyc;
      nc_in_valid = 1'b0;
      i = 0;
      while (!nc_plain_ready && i < 40) begin
        @(negedge clk);
        i++;
      end
      check("nc_plain_text", nc_plain_text, P2);
      check("nc_latency", 128'(cyc - t0), 128'(21));
    end

    // random vectors: fresh key every 4th block, reused key otherwise
    rkey = '0;
    for (int n = 0; n < 1000; n++) begin
      if (n % 4 == 0) rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt = {$urandom, $urandom, $urandom, $urandom};
      send(rkey, aes_enc(rkey, rpt), rpt, (n % 4 == 0) ? 21 : 11, 1'b0);
      wait_done(60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1);
  end
endmodule
